// File: rtl/register_file_pkg.sv
// Shared definitions for the register file and its hazard scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_file_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;
  localparam int CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;
  typedef logic [CNT_W-1:0]      pendCnt_t;

  localparam pendCnt_t CNT_MAX = '1;

  function automatic logic isZeroReg(regAddr_t a);
    return a == regAddr_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Bundle of ID read/issue and WB write signals between pipeline and register file.
// Latency: n/a (wiring only).
// Backpressure: StallOut tells the ID stage to hold its instruction.
// Ports: master = pipeline side (drives addresses, WB, issue); slave = register file.
interface register_file_if;
  import register_file_pkg::*;

  regAddr_t           ID_ReadReg1In;
  regAddr_t           ID_ReadReg2In;
  logic [DATA_W-1:0]  ReadData1Out;
  logic [DATA_W-1:0]  ReadData2Out;
  logic               WB_RegWriteIn;
  regAddr_t           WB_WriteRegIn;
  logic [DATA_W-1:0]  WB_WriteDataIn;
  logic               ID_IssueIn;
  logic               ID_RegWriteIn;
  regAddr_t           ID_DestRegIn;
  logic               StallOut;

  modport master (
    output ID_ReadReg1In, ID_ReadReg2In,
    output WB_RegWriteIn, WB_WriteRegIn, WB_WriteDataIn,
    output ID_IssueIn, ID_RegWriteIn, ID_DestRegIn,
    input  ReadData1Out, ReadData2Out, StallOut
  );

  modport slave (
    input  ID_ReadReg1In, ID_ReadReg2In,
    input  WB_RegWriteIn, WB_WriteRegIn, WB_WriteDataIn,
    input  ID_IssueIn, ID_RegWriteIn, ID_DestRegIn,
    output ReadData1Out, ReadData2Out, StallOut
  );

endinterface

// File: rtl/register_file_reg_scoreboard.sv
// Per-register 2-bit pending-write counters and the operand-hazard stall.
// Latency: stall is combinational; counters update on the next rising edge.
// Backpressure: stall=1 holds ID; a stalled issue changes no counter.
// Ports: clk/rst (async, active-low), two source addresses, WB enable/address,
//        issue/regWrite/dest of the ID instruction, stall out.
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int N_REGS = NUM_REGS
) (
  input  logic     clk,
  input  logic     rst,
  input  regAddr_t readReg1,
  input  regAddr_t readReg2,
  input  logic     wbRegWrite,
  input  regAddr_t wbWriteReg,
  input  logic     issue,
  input  logic     issueRegWrite,
  input  regAddr_t issueDestReg,
  output logic     stall
);

  // Register 0 has no counter; cntView supplies a constant 0 in its place.
  pendCnt_t          cntQ    [1:N_REGS-1];
  pendCnt_t          cntView [N_REGS];
  logic [N_REGS-1:1] incVec;
  logic [N_REGS-1:1] decVec;
  logic              accept;
  logic              busy1;
  logic              busy2;

  // A count of 1 that the WB port is retiring right now is already resolved:
  // the read path bypasses the WB data, so the source need not wait.
  function automatic logic srcBusy(regAddr_t a, pendCnt_t c, logic wbHit);
    return !isZeroReg(a) && (c != '0) && !((c == pendCnt_t'(1)) && wbHit);
  endfunction

  always_comb begin
    cntView[0] = '0;
    for (int i = 1; i < N_REGS; i++) cntView[i] = cntQ[i];
  end

  always_comb begin
    busy1 = srcBusy(readReg1, cntView[readReg1], wbRegWrite && (wbWriteReg == readReg1));
    busy2 = srcBusy(readReg2, cntView[readReg2], wbRegWrite && (wbWriteReg == readReg2));
    stall = busy1 || busy2;
  end

  assign accept = issue && !stall && issueRegWrite && !isZeroReg(issueDestReg);

  always_comb begin
    incVec = '0;
    decVec = '0;
    for (int i = 1; i < N_REGS; i++) begin
      incVec[i] = accept && (issueDestReg == regAddr_t'(i));
      decVec[i] = wbRegWrite && (wbWriteReg == regAddr_t'(i));
    end
  end

  // inc and dec together cancel; overflow at 3 and underflow at 0 hold value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < N_REGS; i++) cntQ[i] <= '0;
    end else begin
      for (int i = 1; i < N_REGS; i++) begin
        if (incVec[i] && !decVec[i] && (cntQ[i] != CNT_MAX))
          cntQ[i] <= cntQ[i] + 1'b1;
        else if (decVec[i] && !incVec[i] && (cntQ[i] != '0))
          cntQ[i] <= cntQ[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with WB bypass and pending-write stall.
// Latency: reads and StallOut combinational; writes land on the next rising edge.
// Backpressure: StallOut asserts while a source operand awaits write-back.
// Ports: Clk, Rst (async, active-low), rf = register_file_if.slave
//        (read addresses/data, WB write port, ID issue info, StallOut).
module register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  register_file_if.slave rf
);
  import register_file_pkg::*;

  logic [DATA_W-1:0] regQ    [1:NUM_REGS-1];
  logic [DATA_W-1:0] regView [NUM_REGS];
  logic              wbActive;
  logic              bypass1;
  logic              bypass2;

  // Bypass is gated by Rst so reads return 0 for the whole reset window,
  // even if the WB port happens to be active.
  assign wbActive = Rst && rf.WB_RegWriteIn && !isZeroReg(rf.WB_WriteRegIn);
  assign bypass1  = wbActive && (rf.WB_WriteRegIn == rf.ID_ReadReg1In);
  assign bypass2  = wbActive && (rf.WB_WriteRegIn == rf.ID_ReadReg2In);

  always_comb begin
    regView[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) regView[i] = regQ[i];
  end

  always_comb begin
    rf.ReadData1Out = bypass1 ? rf.WB_WriteDataIn : regView[rf.ID_ReadReg1In];
    rf.ReadData2Out = bypass2 ? rf.WB_WriteDataIn : regView[rf.ID_ReadReg2In];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 1; i < NUM_REGS; i++) regQ[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wbActive && (rf.WB_WriteRegIn == regAddr_t'(i)))
          regQ[i] <= rf.WB_WriteDataIn;
      end
    end
  end

  reg_scoreboard #(
    .N_REGS(NUM_REGS)
  ) uScoreboard (
    .clk          (Clk),
    .rst          (Rst),
    .readReg1     (rf.ID_ReadReg1In),
    .readReg2     (rf.ID_ReadReg2In),
    .wbRegWrite   (rf.WB_RegWriteIn),
    .wbWriteReg   (rf.WB_WriteRegIn),
    .issue        (rf.ID_IssueIn),
    .issueRegWrite(rf.ID_RegWriteIn),
    .issueDestReg (rf.ID_DestRegIn),
    .stall        (rf.StallOut)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus randomized traffic against a
// behavioural model (register array + per-register outstanding-write counts).
module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   protoFlags = 0;

  register_file_if rfIf();

  register_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .Clk(clk),
    .Rst(rst),
    .rf (rfIf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] mReg  [NUM_REGS];
  int                mPend [NUM_REGS];

  function automatic void modelReset();
    for (int i = 0; i < NUM_REGS; i++) begin
      mReg[i]  = '0;
      mPend[i] = 0;
    end
  endfunction

  function automatic logic [DATA_W-1:0] mRead(regAddr_t a);
    if (rst !== 1'b1 || a == 0) return '0;
    if (rfIf.WB_RegWriteIn && rfIf.WB_WriteRegIn == a) return rfIf.WB_WriteDataIn;
    return mReg[a];
  endfunction

  function automatic logic mBusy(regAddr_t a);
    int n;
    n = mPend[a];
    if (a == 0 || n == 0) return 1'b0;
    if (n == 1 && rfIf.WB_RegWriteIn && rfIf.WB_WriteRegIn == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic mStall();
    return mBusy(rfIf.ID_ReadReg1In) || mBusy(rfIf.ID_ReadReg2In);
  endfunction

  function automatic void modelStep();
    int   wa, da;
    logic wbv, acc;
    if (rst !== 1'b1) begin
      modelReset();
      return;
    end
    wa  = int'(rfIf.WB_WriteRegIn);
    da  = int'(rfIf.ID_DestRegIn);
    wbv = rfIf.WB_RegWriteIn && wa != 0;
    acc = rfIf.ID_IssueIn && !mStall() && rfIf.ID_RegWriteIn && da != 0;
    if (wbv) mReg[wa] = rfIf.WB_WriteDataIn;
    if (acc && wbv && da == wa) return;
    if (acc) begin
      if (mPend[da] == 3) protoFlags++;
      else mPend[da]++;
    end
    if (wbv) begin
      if (mPend[wa] == 0) protoFlags++;
      else mPend[wa]--;
    end
  endfunction

  // Advance one clock: model follows the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input int rs, input int rt);
    rfIf.ID_ReadReg1In  = regAddr_t'(rs);
    rfIf.ID_ReadReg2In  = regAddr_t'(rt);
    rfIf.WB_RegWriteIn  = 1'b0;
    rfIf.WB_WriteRegIn  = '0;
    rfIf.WB_WriteDataIn = '0;
    rfIf.ID_IssueIn     = 1'b0;
    rfIf.ID_RegWriteIn  = 1'b0;
    rfIf.ID_DestRegIn   = '0;
  endtask

  task automatic setWb(input int a, input logic [DATA_W-1:0] d);
    rfIf.WB_RegWriteIn  = 1'b1;
    rfIf.WB_WriteRegIn  = regAddr_t'(a);
    rfIf.WB_WriteDataIn = d;
  endtask

  task automatic setIssue(input int dest);
    rfIf.ID_IssueIn    = 1'b1;
    rfIf.ID_RegWriteIn = 1'b1;
    rfIf.ID_DestRegIn  = regAddr_t'(dest);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle(5, 0);
    setWb(5, 32'hAAAA_5555);
    setIssue(6);
    @(negedge clk);
    total++; if (rfIf.ReadData1Out !== 32'd0) begin bad++; $display("FAIL rst_rd1: got %h want 0", rfIf.ReadData1Out); end
    total++; if (rfIf.ReadData2Out !== 32'd0) begin bad++; $display("FAIL rst_rd2: got %h want 0", rfIf.ReadData2Out); end
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", rfIf.StallOut); end
    tick();
    rst = 1'b1;
    idle(5, 6);
    @(negedge clk);
    total++; if (rfIf.ReadData1Out !== 32'd0) begin bad++; $display("FAIL post_rst_r5: got %h want 0", rfIf.ReadData1Out); end
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL post_rst_stall_r6: got %b want 0", rfIf.StallOut); end
    tick();
  endtask

  task automatic test_bypass();
    idle(3, 3);
    setWb(3, 32'hDEAD_BEEF);
    @(negedge clk);
    total++; if (rfIf.ReadData1Out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rd1: got %h want deadbeef", rfIf.ReadData1Out); end
    total++; if (rfIf.ReadData2Out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rd2: got %h want deadbeef", rfIf.ReadData2Out); end
    tick();
    idle(3, 0);
    @(negedge clk);
    total++; if (rfIf.ReadData1Out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL array_r3: got %h want deadbeef", rfIf.ReadData1Out); end
    total++; if (rfIf.ReadData2Out !== 32'd0) begin bad++; $display("FAIL array_r0: got %h want 0", rfIf.ReadData2Out); end
    tick();
  endtask

  task automatic test_zero_write();
    idle(0, 0);
    setWb(0, 32'h1234_5678);
    @(negedge clk);
    total++; if (rfIf.ReadData1Out !== 32'd0) begin bad++; $display("FAIL r0_bypass: got %h want 0", rfIf.ReadData1Out); end
    tick();
    idle(0, 0);
    @(negedge clk);
    total++; if (rfIf.ReadData2Out !== 32'd0) begin bad++; $display("FAIL r0_array: got %h want 0", rfIf.ReadData2Out); end
    tick();
  endtask

  task automatic test_issue_stall();
    idle(0, 0);
    setIssue(7);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL issue_r7_accept: got %b want 0", rfIf.StallOut); end
    tick();
    idle(7, 0);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL r7_rs_stall: got %b want 1", rfIf.StallOut); end
    tick();
    idle(0, 7);
    setIssue(8);  // stalled issue: must not mark r8 pending
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL r7_rt_stall: got %b want 1", rfIf.StallOut); end
    tick();
    idle(7, 8);
    setWb(7, 32'hCAFE_0007);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL r7_wb_release: got %b want 0", rfIf.StallOut); end
    total++; if (rfIf.ReadData1Out !== 32'hCAFE_0007) begin bad++; $display("FAIL r7_wb_data: got %h want cafe0007", rfIf.ReadData1Out); end
    tick();
    idle(7, 8);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL r7_r8_clear: got %b want 0", rfIf.StallOut); end
    tick();
  endtask

  task automatic test_double_issue();
    for (int k = 0; k < 2; k++) begin
      idle(0, 0);
      setIssue(9);
      tick();
    end
    idle(9, 0);
    setWb(9, 32'h0000_0909);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL r9_cnt2_stall: got %b want 1", rfIf.StallOut); end
    tick();
    idle(9, 0);
    setWb(9, 32'h0000_0999);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL r9_cnt1_wb: got %b want 0", rfIf.StallOut); end
    total++; if (rfIf.ReadData1Out !== 32'h0000_0999) begin bad++; $display("FAIL r9_data: got %h want 00000999", rfIf.ReadData1Out); end
    tick();
  endtask

  task automatic test_saturate();
    // Four issues: the fourth overflows and must leave the count at 3.
    for (int k = 0; k < 4; k++) begin
      idle(0, 0);
      setIssue(12);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      idle(0, 0);
      setWb(12, 32'(k));
      tick();
    end
    idle(12, 0);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL r12_sat_cnt1: got %b want 1", rfIf.StallOut); end
    tick();
    idle(0, 0);
    setWb(12, 32'h12);
    tick();
    // Underflow write-back must hold the count at 0.
    idle(0, 0);
    setWb(12, 32'h13);
    tick();
    idle(0, 0);
    setIssue(12);
    tick();
    idle(0, 12);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL r12_reissue: got %b want 1", rfIf.StallOut); end
    tick();
    idle(0, 0);
    setWb(12, 32'h14);
    tick();
    idle(12, 0);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL r12_no_underflow: got %b want 0", rfIf.StallOut); end
    tick();
  endtask

  task automatic test_same_cycle_and_reset();
    idle(0, 0);
    setIssue(4);
    tick();
    idle(0, 0);
    setIssue(4);
    setWb(4, 32'h0000_0404);
    tick();
    idle(4, 0);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL r4_cnt_held: got %b want 1", rfIf.StallOut); end
    tick();
    idle(0, 0);
    setIssue(10);
    tick();
    idle(4, 3);
    #1;
    total++; if (rfIf.StallOut !== 1'b1) begin bad++; $display("FAIL pre_rst_stall: got %b want 1", rfIf.StallOut); end
    rst = 1'b0;
    modelReset();
    #1;
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL midrst_stall: got %b want 0", rfIf.StallOut); end
    total++; if (rfIf.ReadData2Out !== 32'd0) begin bad++; $display("FAIL midrst_r3: got %h want 0", rfIf.ReadData2Out); end
    setIssue(11);
    tick();
    rst = 1'b1;
    idle(10, 11);
    @(negedge clk);
    total++; if (rfIf.StallOut !== 1'b0) begin bad++; $display("FAIL after_rst_stall: got %b want 0", rfIf.StallOut); end
    tick();
  endtask

  // ---------------- randomized traffic vs model ----------------
  task automatic test_random();
    logic [DATA_W-1:0] e1, e2;
    logic              es;
    int                wa;
    for (int c = 0; c < 400; c++) begin
      idle(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      wa = int'($urandom_range(0, 7));
      if (mPend[wa] > 0 ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1))
        setWb(wa, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        rfIf.ID_IssueIn    = 1'b1;
        rfIf.ID_RegWriteIn = ($urandom_range(0, 4) != 0);
        rfIf.ID_DestRegIn  = regAddr_t'($urandom_range(0, 7));
      end
      @(negedge clk);
      e1 = mRead(rfIf.ID_ReadReg1In);
      e2 = mRead(rfIf.ID_ReadReg2In);
      es = mStall();
      total++; if (rfIf.ReadData1Out !== e1) begin bad++; $display("FAIL rand_rd1 cyc %0d: got %h want %h", c, rfIf.ReadData1Out, e1); end
      total++; if (rfIf.ReadData2Out !== e2) begin bad++; $display("FAIL rand_rd2 cyc %0d: got %h want %h", c, rfIf.ReadData2Out, e2); end
      total++; if (rfIf.StallOut !== es) begin bad++; $display("FAIL rand_stall cyc %0d: got %b want %b", c, rfIf.StallOut, es); end
      tick();
    end
  endtask

  initial begin
    modelReset();
    idle(0, 0);
    test_reset();
    test_bypass();
    test_zero_write();
    test_issue_stall();
    test_double_issue();
    test_saturate();
    test_same_cycle_and_reset();
    test_random();
    $display("protocol violations flagged by model (counter over/underflow): %0d", protoFlags);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
